// File: rtl/load_unit.sv
// MEM-stage load unit: alignment check, word read over valid/ready + rvalid,
// byte/halfword select with sign/zero extension, flushable at any point.
module load_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              m_rd_valid,
  input  logic              m_rd_ready,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_rvalid,
  input  logic [31:0]       m_rd_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_exc
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] off;
  } ld_req_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  state_e            state_q, state_d;
  ld_req_t           req_q, req_d;
  logic [ADDR_W-1:0] m_rd_addr_q, m_rd_addr_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_exc_q, rsp_exc_d;
  logic              req_ok;

  function automatic logic [31:0] extract(input ld_req_t r, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{r.off, 3'b000} +: 8];
    h = r.off[1] ? d[31:16] : d[15:0];
    case (r.op)
      OP_LW:   extract = d;
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'b0, b};
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'b0, h};
      default: extract = 32'b0;
    endcase
  endfunction

  // Legal op and naturally aligned address; bytes never misalign.
  always_comb begin
    case (req_op)
      OP_LW:          req_ok = (req_addr[1:0] == 2'b00);
      OP_LH, OP_LHU:  req_ok = ~req_addr[0];
      OP_LB, OP_LBU:  req_ok = 1'b1;
      default:        req_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    m_rd_addr_d = m_rd_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_exc_d   = rsp_exc_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          req_d.op    = req_op;
          req_d.off   = req_addr[1:0];
          m_rd_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          rsp_data_d  = 32'b0;
          rsp_exc_d   = ~req_ok;
          state_d     = req_ok ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (flush)           state_d = S_IDLE;
        else if (m_rd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A flush after the address handshake must still absorb the rvalid.
        if (flush) begin
          state_d = m_rd_rvalid ? S_IDLE : S_DRAIN;
        end else if (m_rd_rvalid) begin
          rsp_data_d = extract(req_q, m_rd_rdata);
          rsp_exc_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_DRAIN: begin
        if (m_rd_rvalid) state_d = S_IDLE;
      end
      S_RESP: begin
        if (flush || rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      m_rd_addr_q <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      m_rd_addr_q <= m_rd_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_exc_q   <= rsp_exc_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign m_rd_valid = (state_q == S_REQ);
  assign m_rd_addr  = m_rd_addr_q;
  assign rsp_valid  = (state_q == S_RESP);
  // Data/exc only visible while a response is presented, so reset and idle read as 0.
  assign rsp_data   = rsp_valid ? rsp_data_q : 32'b0;
  assign rsp_exc    = rsp_valid & rsp_exc_q;

endmodule

// File: tb/tb_load_unit.sv
// Randomized bench for load_unit: cycle-stepped driver acting as pipeline,
// memory and writeback, checked against an arithmetic load model.
module tb_load_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic        m_rd_valid;
  logic        m_rd_ready = 1'b0;
  logic [31:0] m_rd_addr;
  logic        m_rd_rvalid = 1'b0;
  logic [31:0] m_rd_rdata = 32'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_exc;

  int total = 0;
  int bad = 0;

  load_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_addr(m_rd_addr),
    .m_rd_rvalid(m_rd_rvalid), .m_rd_rdata(m_rd_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exc(rsp_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Load semantics from first principles: shift out the addressed byte/half.
  function automatic void ref_load(input int unsigned op, input int unsigned addr,
                                   input int unsigned rdata, output bit exc,
                                   output int unsigned data);
    int unsigned b, h;
    b = (rdata >> (8 * (addr % 4))) % 256;
    h = (rdata >> (16 * ((addr / 2) % 2))) % 65536;
    exc = (op > 4) || (op == 0 && addr % 4 != 0) || ((op == 3 || op == 4) && addr % 2 != 0);
    data = 0;
    if (!exc) begin
      case (op)
        0: data = rdata;
        1: data = (b >= 128) ? b + 32'hFFFFFF00 : b;
        2: data = b;
        3: data = (h >= 32768) ? h + 32'hFFFF0000 : h;
        default: data = h;
      endcase
    end
  endfunction

  // fmode: 0 none, 1 flush in REQ (with m_rd_ready), 2 flush in WAIT then drain,
  // 3 flush in RESP, 4 flush together with rvalid.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                          input int rdy_dly, input int rv_dly, input int rsp_dly, input int fmode);
    bit          exc;
    int unsigned exp_data;
    logic [31:0] waddr;
    ref_load(op, addr, rdata, exc, exp_data);
    waddr = addr & 32'hFFFF_FFFC;
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom;
    if (!exc) begin
      for (int i = 0; i < rdy_dly; i++) begin
        chk("req_mvalid", m_rd_valid, 1);
        chk("req_maddr", m_rd_addr, waddr);
        chk("req_rdy0", req_ready, 0);
        @(negedge clk);
      end
      chk("req_mvalid", m_rd_valid, 1);
      chk("req_maddr", m_rd_addr, waddr);
      m_rd_ready = 1'b1;
      if (fmode == 1) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; m_rd_ready = 1'b0;
        chk("freq_mvalid", m_rd_valid, 0);
        chk("freq_rdy", req_ready, 1);
        chk("freq_rspv", rsp_valid, 0);
        return;
      end
      @(negedge clk);
      m_rd_ready = 1'b0;
      for (int i = 0; i < rv_dly; i++) begin
        chk("wait_mvalid", m_rd_valid, 0);
        chk("wait_rspv", rsp_valid, 0);
        m_rd_rdata = $urandom;
        @(negedge clk);
      end
      if (fmode == 2) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
          chk("drain_rdy0", req_ready, 0);
          chk("drain_rspv", rsp_valid, 0);
          @(negedge clk);
        end
        chk("drain_rdy0", req_ready, 0);
        m_rd_rvalid = 1'b1; m_rd_rdata = rdata;
        @(negedge clk);
        m_rd_rvalid = 1'b0;
        chk("drain_done_rdy", req_ready, 1);
        chk("drain_done_rspv", rsp_valid, 0);
        return;
      end
      m_rd_rvalid = 1'b1; m_rd_rdata = rdata;
      if (fmode == 4) flush = 1'b1;
      @(negedge clk);
      m_rd_rvalid = 1'b0; flush = 1'b0; m_rd_rdata = $urandom;
      if (fmode == 4) begin
        chk("frv_rdy", req_ready, 1);
        chk("frv_rspv", rsp_valid, 0);
        return;
      end
    end
    for (int i = 0; i <= rsp_dly; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_exc", rsp_exc, exc);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_rdy0", req_ready, 0);
      if (exc) chk("exc_mvalid", m_rd_valid, 0);
      if (i < rsp_dly) @(negedge clk);
    end
    if (fmode == 3) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end else begin
      // Offer a new request in the handshake cycle; it must not be taken.
      rsp_ready = 1'b1; req_valid = 1'b1; req_op = 3'b001; req_addr = 32'h40;
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b0;
    end
    chk("post_rspv", rsp_valid, 0);
    chk("post_rdy", req_ready, 1);
    chk("post_mvalid", m_rd_valid, 0);
  endtask

  initial begin
    int fm;
    logic [2:0] op;
    logic [31:0] addr;
    #1;
    chk("rst_rdy", req_ready, 1);
    chk("rst_mvalid", m_rd_valid, 0);
    chk("rst_maddr", m_rd_addr, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_exc", rsp_exc, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_rdy", req_ready, 1);

    run_load(3'b001, 32'h1003, 32'h80FF7F01, 0, 0, 0, 0);
    run_load(3'b010, 32'h1003, 32'h80FF7F01, 0, 0, 0, 0);
    run_load(3'b011, 32'h2002, 32'h9ABC1234, 0, 0, 0, 0);
    run_load(3'b100, 32'h2000, 32'h9ABC1234, 0, 0, 0, 0);
    run_load(3'b000, 32'h2000, 32'h9ABC1234, 0, 0, 0, 0);
    run_load(3'b000, 32'h1002, 32'h12345678, 0, 0, 0, 0);
    run_load(3'b011, 32'h1001, 32'h12345678, 0, 0, 1, 0);
    run_load(3'b111, 32'h1000, 32'h12345678, 0, 0, 0, 0);
    run_load(3'b011, 32'h3002, 32'h7FFF8001, 3, 2, 2, 0);
    run_load(3'b010, 32'h3001, 32'hDEADBEEF, 0, 1, 4, 2);
    run_load(3'b010, 32'h3001, 32'hDEADBEEF, 0, 0, 0, 0);

    // Flush during IDLE blocks acceptance.
    req_valid = 1'b1; req_op = 3'b000; req_addr = 32'h100; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("fidle_rdy", req_ready, 1);
    chk("fidle_mvalid", m_rd_valid, 0);
    chk("fidle_rspv", rsp_valid, 0);

    // Asynchronous reset while a response is presented.
    req_valid = 1'b1; req_op = 3'b000; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0; m_rd_ready = 1'b1;
    @(negedge clk);
    m_rd_ready = 1'b0; m_rd_rvalid = 1'b1; m_rd_rdata = 32'hCAFEF00D;
    @(negedge clk);
    m_rd_rvalid = 1'b0;
    chk("arst_pre_data", rsp_data, 32'hCAFEF00D);
    #2 reset = 1'b0;
    #1;
    chk("arst_rspv", rsp_valid, 0);
    chk("arst_data", rsp_data, 0);
    chk("arst_exc", rsp_exc, 0);
    chk("arst_maddr", m_rd_addr, 0);
    chk("arst_mvalid", m_rd_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("arst_rel_rdy", req_ready, 1);

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 3'b000) addr[1:0] = 2'b00;
        else if (op == 3'b011 || op == 3'b100) addr[0] = 1'b0;
      end
      fm = $urandom_range(0, 9);
      fm = (fm < 6) ? 0 : fm - 5;
      run_load(op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), fm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
